// File: rtl/ram_cmd_pkg.sv
// Shared types and command-word layout for the RAM read-command splitter.
package ram_cmd_pkg;

  // Splitter control states: wait for a request, size the next burst, present it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  // tdata layout is {last, len, addr}; the address always sits at bit 0.
  localparam int ADDR_LSB = 0;

  // Length field starts right above the address field.
  function automatic int cmd_len_lsb(input int addr_w);
    return addr_w;
  endfunction

  // The last flag is the top bit of the command word.
  function automatic int cmd_last_bit(input int addr_w, input int len_w);
    return addr_w + len_w;
  endfunction

  // Total command word width.
  function automatic int cmd_width(input int addr_w, input int len_w);
    return addr_w + len_w + 1;
  endfunction

endpackage

// File: rtl/ram_cmd_rr_arb.sv
// Round-robin arbiter: one-hot grant computed combinationally from the request
// vector, searching upward from the channel after the last one granted.
module ram_cmd_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any_req
);

  logic [CH_W-1:0] last_grant_q;
  logic [CH_W-1:0] last_grant_d;
  int              cand;

  // Pick the first requesting channel after last_grant, wrapping modulo NUM_CH.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = (int'(last_grant_q) + off) % NUM_CH;
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant_idx   = CH_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  // The pointer only moves when the grant is actually taken.
  always_comb begin
    last_grant_d = last_grant_q;
    if (advance && any_req) begin
      last_grant_d = grant_idx;
    end
  end

  // Pointer register; reset to the top channel so channel 0 wins first.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ram_read_cmd_splitter.sv
// Multi-channel read-command source: arbitrates byte-length requests and splits
// each into bursts capped at MAX_BURST that never cross a BOUNDARY address.
module ram_read_cmd_splitter
  import ram_cmd_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 32,
  parameter int MAX_BURST = 4096,
  parameter int BOUNDARY  = 4096,
  localparam int CMD_W    = cmd_width(ADDR_W, LEN_W),
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*LEN_W-1:0]  req_len,
  output logic                     cmd_tvalid,
  input  logic                     cmd_tready,
  output logic [CMD_W-1:0]         cmd_tdata,
  output logic [CH_W-1:0]          cmd_tdest,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        err_zero_len,
  output logic                     busy
);

  localparam int LEN_LSB  = cmd_len_lsb(ADDR_W);
  localparam int LAST_BIT = cmd_last_bit(ADDR_W, LEN_W);
  localparam int BLOG     = $clog2(BOUNDARY);
  localparam int BW       = BLOG + 1;
  localparam int CW       = (BW > LEN_W) ? BW : LEN_W;

  // Reject parameter sets the burst arithmetic cannot handle.
  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..16");
  end
  if ((MAX_BURST <= 0) || ((MAX_BURST & (MAX_BURST - 1)) != 0)) begin : g_bad_max_burst
    $error("MAX_BURST must be a power of 2");
  end
  if ((BOUNDARY <= 0) || ((BOUNDARY & (BOUNDARY - 1)) != 0)) begin : g_bad_boundary
    $error("BOUNDARY must be a power of 2");
  end
  if (MAX_BURST > BOUNDARY) begin : g_bad_ratio
    $error("MAX_BURST must not exceed BOUNDARY");
  end
  if ($clog2(MAX_BURST) >= LEN_W) begin : g_bad_len_w
    $error("MAX_BURST must fit in LEN_W bits");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  chunk_q, chunk_d;
  logic              last_q, last_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   tdest_q, tdest_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] err_q, err_d;

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              any_req;
  logic              accept;
  logic              handshake;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic [BW-1:0]     addr_mod;
  logic [BW-1:0]     to_bnd;
  logic [CW-1:0]     chunk_x;
  logic [LEN_W-1:0]  chunk_c;

  ram_cmd_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .req           (req_valid),
    .advance       (accept),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .any_req       (any_req)
  );

  assign accept    = (state_q == IDLE) && any_req;
  assign handshake = (state_q == EMIT) && cmd_tready;

  // Select the winning channel's address and length from the one-hot grant.
  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        win_addr |= req_addr[i*ADDR_W +: ADDR_W];
        win_len  |= req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Next burst size: smallest of remaining bytes, burst cap and distance to boundary.
  always_comb begin
    addr_mod = BW'(addr_q & ADDR_W'(BOUNDARY - 1));
    to_bnd   = BW'(BOUNDARY) - addr_mod;
    chunk_x  = CW'(rem_q);
    if (CW'(MAX_BURST) < chunk_x) begin
      chunk_x = CW'(MAX_BURST);
    end
    if (CW'(to_bnd) < chunk_x) begin
      chunk_x = CW'(to_bnd);
    end
    chunk_c = LEN_W'(chunk_x);
  end

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; zero-length requests are consumed without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req && (win_len != '0)) state_d = CALC;
      CALC:    state_d = EMIT;
      EMIT:    if (cmd_tready) state_d = last_q ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    req_ready  = (state_q == IDLE) ? grant : '0;
    cmd_tvalid = (state_q == EMIT);
    busy       = (state_q != IDLE);
  end

  // Datapath next values: latch on accept, size in CALC, advance on handshake.
  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    ch_d    = ch_q;
    chunk_d = chunk_q;
    last_d  = last_q;
    tdest_d = tdest_q;
    done_d  = '0;
    err_d   = '0;
    if (accept) begin
      addr_d = win_addr;
      rem_d  = win_len;
      ch_d   = grant_idx;
      if (win_len == '0) begin
        err_d = grant;
      end
    end
    if (state_q == CALC) begin
      chunk_d = chunk_c;
      last_d  = (chunk_c == rem_q);
      tdest_d = ch_q;
    end
    if (handshake) begin
      addr_d = addr_q + ADDR_W'(chunk_q);
      rem_d  = rem_q - chunk_q;
      if (last_q) begin
        done_d = NUM_CH'(1) << ch_q;
      end
    end
  end

  // Datapath registers; a reset drops any partially emitted request.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      addr_q  <= '0;
      rem_q   <= '0;
      ch_q    <= '0;
      chunk_q <= '0;
      last_q  <= 1'b0;
      tdest_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      ch_q    <= ch_d;
      chunk_q <= chunk_d;
      last_q  <= last_d;
      tdest_q <= tdest_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Command word assembly; all fields come straight from registers.
  always_comb begin
    cmd_tdata                           = '0;
    cmd_tdata[ADDR_LSB +: ADDR_W]       = addr_q;
    cmd_tdata[LEN_LSB +: LEN_W]         = chunk_q;
    cmd_tdata[LAST_BIT]                 = last_q;
  end

  assign cmd_tdest    = tdest_q;
  assign done         = done_q;
  assign err_zero_len = err_q;

endmodule

// File: doc/ram_read_cmd_splitter.md
Name: ram_read_cmd_splitter

Overview:
Parametrised successor to the single-channel RAM controller read-command source. It accepts byte-length read requests from NUM_CH independent channels and arbitrates between them round-robin. Each request is split into bursts that never exceed MAX_BURST bytes and never cross a BOUNDARY-aligned address. The bursts are emitted on one AXI-Stream read-command port toward the RAM controller, with a per-channel tag on tdest and a per-channel completion pulse usable as an f2h IRQ source.

Parameters:
NUM_CH, 4, number of requesting channels (1..16)
ADDR_W, 64, byte-address width
LEN_W, 32, byte-length width
MAX_BURST, 4096, maximum bytes per emitted command; power of 2
BOUNDARY, 4096, address boundary a command must not cross; power of 2, >= MAX_BURST
CMD_W, ADDR_W+LEN_W+1, derived tdata width (97 at defaults)
CH_W, max(1,clog2(NUM_CH)), derived tdest width

Ports:
clk_clk  in  1  single clock
reset_reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel request accept, one-hot
req_addr  in  NUM_CH*ADDR_W  start byte address, channel i at [i*ADDR_W +: ADDR_W]
req_len  in  NUM_CH*LEN_W  byte length, channel i at [i*LEN_W +: LEN_W]
cmd_tvalid  out  1  command valid
cmd_tready  in  1  command ready
cmd_tdata  out  CMD_W  {last, len[LEN_W-1:0], addr[ADDR_W-1:0]}
cmd_tdest  out  CH_W  originating channel
done  out  NUM_CH  one-cycle pulse when the last command of a request is accepted
err_zero_len  out  NUM_CH  one-cycle pulse when a zero-length request is accepted
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock/reset: one clock, clk_clk; reset_reset_n is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer set so channel 0 has highest priority.
- Reset mid-operation: an in-flight command is dropped without handshake and the partial request is lost.
- FSM states: IDLE, CALC, EMIT.
- IDLE, some req_valid high:
  - The round-robin winner g is the first valid channel searching from last_grant+1, modulo NUM_CH.
  - req_ready[g] = 1 in the same cycle (combinational from req_valid and the pointer). No other req_ready bit is high.
  - addr/rem/ch registers latch the winner's request; last_grant becomes g.
  - If req_len == 0: pulse err_zero_len[g] next cycle, stay in IDLE, emit no command and no done pulse.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - chunk = min(rem, MAX_BURST, BOUNDARY - (addr mod BOUNDARY)).
  - last = (chunk == rem).
  - Register cmd_tdata and cmd_tdest, then go to EMIT.
- EMIT:
  - cmd_tvalid = 1.
  - tdata and tdest stay stable until cmd_tvalid && cmd_tready.
  - tvalid never drops without a handshake.
  - On handshake:
    - addr += chunk, modulo 2^ADDR_W (wrap is legal).
    - rem -= chunk.
    - If last: pulse done[ch] in the next cycle and go to IDLE; otherwise go to CALC.
- Latency and throughput:
  - First tvalid appears 2 cycles after request acceptance.
  - One command per 2 cycles at most; one idle cycle between requests.
- New requests are not accepted outside IDLE.
- req_valid may drop without being accepted.
- Arithmetic widths:
  - Compute the boundary remainder at clog2(BOUNDARY)+1 bits.
  - Compute chunk at LEN_W bits; MAX_BURST must fit in LEN_W.
- Elaboration-time checks: power-of-2 parameters and MAX_BURST <= BOUNDARY.

Decomposition:
- Package ram_cmd_pkg holds:
  - the state enum (IDLE/CALC/EMIT);
  - the tdata field-offset localparams (ADDR_LSB, LEN_LSB, LAST_BIT);
  - a function computing CMD_W.
- Sub-module ram_cmd_rr_arb: NUM_CH-wide round-robin arbiter with a combinational one-hot grant, a pointer update on an advance strobe, and async active-low reset.

Test Plan:
1. Single request: ch0 addr 0x1000, len 0x100 -> one cmd {last=1, len=0x100, addr=0x1000}, tdest=0; done[0] pulses 1 cycle after the handshake; first tvalid 2 cycles after req_ready.
2. Boundary split: ch1 addr 0x0FF0, len 0x40 -> cmd (0x0FF0, 0x10, last=0) then (0x1000, 0x30, last=1), both tdest=1.
3. Large request: ch2 addr 0x0, len 0x2800 -> (0x0, 0x1000), (0x1000, 0x1000), (0x2000, 0x800, last=1); done[2] pulses exactly once.
4. Backpressure: cmd_tready held low 10 cycles during test 3 -> tdata and tdest constant, tvalid stays high, no duplicate or skipped chunk.
5. Round-robin: all 4 channels valid continuously with len 0x10 -> grant order 0,1,2,3,0; no starvation.
6. Zero length and reset:
   - Zero length: ch3 len 0 -> err_zero_len[3] pulse, no cmd, no done.
   - Reset: assert reset_reset_n low during EMIT -> tvalid and busy 0 immediately; after release, ch0 has priority and a new request completes normally.
